// File: rtl/ps2_kbd_decoder_pkg.sv
// ps2_kbd_decoder_pkg: shared byte constants, decode states
// and event word layout for the PS/2 keyboard decoder.
package ps2_kbd_decoder_pkg;

   localparam logic [7:0] PS2_EXT      = 8'hE0;
   localparam logic [7:0] PS2_BRK      = 8'hF0;
   localparam logic [7:0] PS2_PAUSE    = 8'hE1;
   localparam logic [7:0] PS2_BAT_OK   = 8'hAA;
   localparam logic [7:0] PS2_BAT_FAIL = 8'hFC;
   localparam logic [7:0] PS2_ACK      = 8'hFA;
   localparam logic [7:0] PS2_RESEND   = 8'hFE;
   localparam logic [7:0] PS2_ECHO     = 8'hEE;
   localparam logic [7:0] PS2_OVF_LO   = 8'h00;
   localparam logic [7:0] PS2_OVF_HI   = 8'hFF;
   localparam logic [7:0] PS2_PAUSE_CD = 8'h77;

   // bytes following E1 that make up the Pause sequence
   localparam logic [2:0] PAUSE_LEN = 3'd7;

   localparam int EVT_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXT,
      ST_BRK,
      ST_EXT_BRK,
      ST_PAUSE
   } state_e;

   typedef struct packed {
      logic       pause;
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } evt_t;

   function automatic evt_t mk_evt(
      input logic [7:0] code,
      input logic       ext,
      input logic       brk,
      input logic       pause
   );
      evt_t e;
      e.pause = pause;
      e.ext   = ext;
      e.brk   = brk;
      e.code  = code;
      return e;
   endfunction

   function automatic logic is_prefix(input logic [7:0] b);
      return (b == PS2_EXT) || (b == PS2_BRK) || (b == PS2_PAUSE);
   endfunction

endpackage

// File: rtl/ps2_kbd_decoder_fifo.sv
// ps2_kbd_decoder_fifo: synchronous first-word-fall-through
// event FIFO; a write into a full FIFO succeeds only with a pop.
module ps2_kbd_decoder_fifo #(
   parameter int WIDTH = 11,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     wr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic                     rd_i,
   output logic [WIDTH-1:0]         rdata_o,
   output logic                     empty_o,
   output logic                     wr_ok_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             full, rd_ok, wr_ok;

   // accept logic and next pointers/count
   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty_o  = (count_q == '0);
      rd_ok    = rd_i & ~empty_o;
      wr_ok    = wr_i & (~full | rd_ok);
      wr_ptr_d = wr_ptr_q + AW'(wr_ok);
      rd_ptr_d = rd_ptr_q + AW'(rd_ok);
      count_d  = count_q + CW'(wr_ok) - CW'(rd_ok);
   end

   // pointer and occupancy registers
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // storage array, written only on accepted pushes
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[rd_ptr_q];
   assign wr_ok_o = wr_ok;
   assign count_o = count_q;

endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: turns scan-code-set-2 bytes into key events
// with prefix handling, event buffering and line back-pressure.
module ps2_kbd_decoder
   import ps2_kbd_decoder_pkg::*;
#(
   parameter int FIFO_DEPTH  = 8,
   parameter int HOLD_MARGIN = 2,
   parameter int PFX_TIMEOUT = 50000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rcv_data,
   input  logic       rcv_vld,
   input  logic       rcv_parity_err,
   input  logic       rcv_no_stop_err,
   output logic       hold_req,
   output logic       evt_vld,
   input  logic       evt_rdy,
   output logic [7:0] evt_code,
   output logic       evt_ext,
   output logic       evt_brk,
   output logic       evt_pause,
   output logic       frame_err,
   output logic       bat_ok,
   output logic       bat_fail,
   output logic       kbd_ovf,
   output logic       evt_ovf,
   input  logic       ovf_clr
);

   localparam int TW = $clog2(PFX_TIMEOUT + 1);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   state_e        state_q, state_d;
   logic [2:0]    pcnt_q, pcnt_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          push_q, push_d;
   evt_t          pdata_q, pdata_d;
   logic          ferr_q, ferr_d;
   logic          bok_q, bok_d;
   logic          bfail_q, bfail_d;
   logic          kovf_q, kovf_d;
   logic          ovf_q, ovf_d;
   logic          hold_q, hold_d;

   logic [EVT_W-1:0] head_raw;
   evt_t             head;
   logic             empty, wr_ok, pop;
   logic [CW-1:0]    cnt, cnt_nxt;

   // byte-driven decode FSM with prefix timeout
   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      tcnt_d  = '0;
      push_d  = 1'b0;
      pdata_d = '0;
      ferr_d  = 1'b0;
      bok_d   = 1'b0;
      bfail_d = 1'b0;
      kovf_d  = 1'b0;
      if (rcv_vld) begin
         if (rcv_parity_err | rcv_no_stop_err) begin
            ferr_d  = 1'b1;
            state_d = ST_IDLE;
         end else begin
            case (state_q)
               ST_IDLE: begin
                  case (rcv_data)
                     PS2_EXT:   state_d = ST_EXT;
                     PS2_BRK:   state_d = ST_BRK;
                     PS2_PAUSE: begin
                        state_d = ST_PAUSE;
                        pcnt_d  = PAUSE_LEN;
                     end
                     PS2_BAT_OK:   bok_d   = 1'b1;
                     PS2_BAT_FAIL: bfail_d = 1'b1;
                     PS2_OVF_LO,
                     PS2_OVF_HI:   kovf_d  = 1'b1;
                     PS2_ACK,
                     PS2_RESEND,
                     PS2_ECHO: ;
                     default: begin
                        push_d  = 1'b1;
                        pdata_d = mk_evt(rcv_data, 1'b0, 1'b0, 1'b0);
                     end
                  endcase
               end
               ST_EXT: begin
                  if (rcv_data == PS2_BRK) begin
                     state_d = ST_EXT_BRK;
                  end else begin
                     state_d = ST_IDLE;
                     if (!is_prefix(rcv_data)) begin
                        push_d  = 1'b1;
                        pdata_d = mk_evt(rcv_data, 1'b1, 1'b0, 1'b0);
                     end
                  end
               end
               ST_BRK: begin
                  state_d = ST_IDLE;
                  if (!is_prefix(rcv_data)) begin
                     push_d  = 1'b1;
                     pdata_d = mk_evt(rcv_data, 1'b0, 1'b1, 1'b0);
                  end
               end
               ST_EXT_BRK: begin
                  state_d = ST_IDLE;
                  if (!is_prefix(rcv_data)) begin
                     push_d  = 1'b1;
                     pdata_d = mk_evt(rcv_data, 1'b1, 1'b1, 1'b0);
                  end
               end
               ST_PAUSE: begin
                  if (pcnt_q == 3'd1) begin
                     state_d = ST_IDLE;
                     push_d  = 1'b1;
                     pdata_d = mk_evt(PS2_PAUSE_CD, 1'b0, 1'b0, 1'b1);
                  end else begin
                     pcnt_d = pcnt_q - 3'd1;
                  end
               end
               default: state_d = ST_IDLE;
            endcase
         end
      end else if (state_q != ST_IDLE) begin
         if (tcnt_q == TW'(PFX_TIMEOUT - 1)) begin
            state_d = ST_IDLE;
         end else begin
            tcnt_d = tcnt_q + TW'(1);
         end
      end
   end

   // decode state, counters and registered pulses
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         pcnt_q  <= '0;
         tcnt_q  <= '0;
         push_q  <= 1'b0;
         pdata_q <= '0;
         ferr_q  <= 1'b0;
         bok_q   <= 1'b0;
         bfail_q <= 1'b0;
         kovf_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         tcnt_q  <= tcnt_d;
         push_q  <= push_d;
         pdata_q <= pdata_d;
         ferr_q  <= ferr_d;
         bok_q   <= bok_d;
         bfail_q <= bfail_d;
         kovf_q  <= kovf_d;
      end
   end

   ps2_kbd_decoder_fifo #(
      .WIDTH (EVT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_i    (push_q),
      .wdata_i (pdata_q),
      .rd_i    (evt_rdy),
      .rdata_o (head_raw),
      .empty_o (empty),
      .wr_ok_o (wr_ok),
      .count_o (cnt)
   );

   // overflow flag and hold request from next occupancy
   always_comb begin
      pop     = ~empty & evt_rdy;
      cnt_nxt = cnt + CW'(wr_ok) - CW'(pop);
      ovf_d   = ovf_clr ? 1'b0 : (ovf_q | (push_q & ~wr_ok));
      hold_d  = (FIFO_DEPTH - int'(cnt_nxt)) <= HOLD_MARGIN;
   end

   // sticky overflow and hold request registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q  <= 1'b0;
         hold_q <= 1'b0;
      end else begin
         ovf_q  <= ovf_d;
         hold_q <= hold_d;
      end
   end

   assign head      = evt_t'(head_raw);
   assign evt_vld   = ~empty;
   assign evt_code  = evt_vld ? head.code : 8'h00;
   assign evt_ext   = evt_vld & head.ext;
   assign evt_brk   = evt_vld & head.brk;
   assign evt_pause = evt_vld & head.pause;
   assign frame_err = ferr_q;
   assign bat_ok    = bok_q;
   assign bat_fail  = bfail_q;
   assign kbd_ovf   = kovf_q;
   assign evt_ovf   = ovf_q;
   assign hold_req  = hold_q;

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed byte sequences with an expected
// event queue checked as the decoder emits events.
module tb_ps2_kbd_decoder;

   localparam int DEPTH = 8;
   localparam int TMO   = 100;

   logic       clk;
   logic       rst;
   logic [7:0] rcv_data;
   logic       rcv_vld;
   logic       rcv_parity_err;
   logic       rcv_no_stop_err;
   logic       hold_req;
   logic       evt_vld;
   logic       evt_rdy;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_pause;
   logic       frame_err;
   logic       bat_ok;
   logic       bat_fail;
   logic       kbd_ovf;
   logic       evt_ovf;
   logic       ovf_clr;

   int total = 0;
   int bad   = 0;

   logic [10:0] exp_q [$];

   ps2_kbd_decoder #(
      .FIFO_DEPTH  (DEPTH),
      .HOLD_MARGIN (2),
      .PFX_TIMEOUT (TMO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .rcv_data        (rcv_data),
      .rcv_vld         (rcv_vld),
      .rcv_parity_err  (rcv_parity_err),
      .rcv_no_stop_err (rcv_no_stop_err),
      .hold_req        (hold_req),
      .evt_vld         (evt_vld),
      .evt_rdy         (evt_rdy),
      .evt_code        (evt_code),
      .evt_ext         (evt_ext),
      .evt_brk         (evt_brk),
      .evt_pause       (evt_pause),
      .frame_err       (frame_err),
      .bat_ok          (bat_ok),
      .bat_fail        (bat_fail),
      .kbd_ovf         (kbd_ovf),
      .evt_ovf         (evt_ovf),
      .ovf_clr         (ovf_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   function automatic logic [10:0] ev(input logic [7:0] code,
                                      input logic ext, input logic brk,
                                      input logic pause);
      return {pause, ext, brk, code};
   endfunction

   // pops the scoreboard on every accepted event
   always @(negedge clk) begin
      logic [10:0] got;
      logic [10:0] want;
      if (!rst && evt_vld && evt_rdy) begin
         got = {evt_pause, evt_ext, evt_brk, evt_code};
         if (exp_q.size() == 0) begin
            chk("evt_spurious", 32'(got), 32'hFFFF_FFFF);
         end else begin
            want = exp_q.pop_front();
            chk("evt", 32'(got), 32'(want));
         end
      end
   end

   task automatic send(input logic [7:0] b, input logic perr = 1'b0,
                       input logic serr = 1'b0);
      @(posedge clk); #1;
      rcv_data        = b;
      rcv_vld         = 1'b1;
      rcv_parity_err  = perr;
      rcv_no_stop_err = serr;
      @(posedge clk); #1;
      rcv_vld         = 1'b0;
      rcv_parity_err  = 1'b0;
      rcv_no_stop_err = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         tick(1);
         n++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
      tick(3);
   endtask

   initial begin
      rst             = 1'b1;
      rcv_data        = 8'h00;
      rcv_vld         = 1'b0;
      rcv_parity_err  = 1'b0;
      rcv_no_stop_err = 1'b0;
      evt_rdy         = 1'b1;
      ovf_clr         = 1'b0;
      tick(3);
      chk("reset_outs",
          32'({evt_vld, evt_code, evt_ext, evt_brk, evt_pause, frame_err,
               bat_ok, bat_fail, kbd_ovf, evt_ovf, hold_req}), 32'd0);
      rst = 1'b0;
      tick(2);

      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b0));
      send(8'h1C);
      chk("make_vld_1clk", 32'(evt_vld), 32'd0);
      tick(1);
      chk("make_vld_2clk", 32'(evt_vld), 32'd1);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b1, 1'b0));
      send(8'hF0);
      send(8'h1C);
      drain("drain_makebrk");

      send(8'hE0);
      tick(3);
      chk("pfx_no_evt", 32'(evt_vld), 32'd0);
      exp_q.push_back(ev(8'h75, 1'b1, 1'b0, 1'b0));
      send(8'h75);
      exp_q.push_back(ev(8'h75, 1'b1, 1'b1, 1'b0));
      send(8'hE0);
      send(8'hF0);
      send(8'h75);
      drain("drain_ext");

      send(8'hE1);
      send(8'h14);
      send(8'h77);
      send(8'hE1);
      send(8'hF0);
      send(8'h14);
      send(8'hF0);
      tick(3);
      chk("pause_mid_none", 32'(evt_vld), 32'd0);
      exp_q.push_back(ev(8'h77, 1'b0, 1'b0, 1'b1));
      send(8'h77);
      drain("drain_pause");

      send(8'hE0);
      send(8'h75, 1'b1, 1'b0);
      chk("frame_err_pulse", 32'(frame_err), 32'd1);
      tick(1);
      chk("frame_err_clear", 32'(frame_err), 32'd0);
      send(8'h66, 1'b0, 1'b1);
      chk("stop_err_pulse", 32'(frame_err), 32'd1);
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b0));
      send(8'h1C);
      drain("drain_err");

      send(8'hF0);
      tick(TMO + 5);
      exp_q.push_back(ev(8'h2A, 1'b0, 1'b0, 1'b0));
      send(8'h2A);
      drain("drain_timeout");

      evt_rdy = 1'b0;
      for (int i = 0; i < 9; i++) begin
         if (i < DEPTH) exp_q.push_back(ev(8'h15 + 8'(i), 1'b0, 1'b0, 1'b0));
         send(8'h15 + 8'(i));
         tick(1);
         if (i == 4) chk("hold_cnt5", 32'(hold_req), 32'd0);
         if (i == 5) chk("hold_cnt6", 32'(hold_req), 32'd1);
         if (i == 7) chk("ovf_at_full", 32'(evt_ovf), 32'd0);
      end
      chk("ovf_set", 32'(evt_ovf), 32'd1);
      chk("head_stable", 32'({evt_vld, evt_code}), 32'h115);
      @(posedge clk); #1;
      ovf_clr = 1'b1;
      @(posedge clk); #1;
      ovf_clr = 1'b0;
      chk("ovf_clr", 32'(evt_ovf), 32'd0);
      evt_rdy = 1'b1;
      drain("drain_full");
      chk("hold_release", 32'(hold_req), 32'd0);

      send(8'hAA);
      chk("bat_ok", 32'({bat_ok, bat_fail, kbd_ovf}), 32'h4);
      send(8'hFC);
      chk("bat_fail", 32'({bat_ok, bat_fail, kbd_ovf}), 32'h2);
      send(8'h00);
      chk("kbd_ovf", 32'({bat_ok, bat_fail, kbd_ovf}), 32'h1);
      send(8'hFA);
      chk("ack_quiet",
          32'({bat_ok, bat_fail, kbd_ovf, frame_err}), 32'd0);
      tick(3);
      chk("ack_no_evt", 32'(evt_vld), 32'd0);

      evt_rdy = 1'b0;
      send(8'h31);
      send(8'h32);
      send(8'hE0);
      tick(2);
      chk("pre_rst_vld", 32'(evt_vld), 32'd1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("rst_flush",
          32'({evt_vld, hold_req, evt_ovf}), 32'd0);
      evt_rdy = 1'b1;
      exp_q.push_back(ev(8'h1C, 1'b0, 1'b0, 1'b0));
      send(8'h1C);
      drain("drain_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
